// File: rtl/ascii_num_parser.sv
// Streaming ASCII decimal parser: converts whitespace/comma separated signed integers
// to two's complement and writes them to consecutive RAM addresses after clearing the RAM.
module ascii_num_parser #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  ram_clear,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH:0]   num_count,
  output logic                  done,
  output logic                  err_fmt,
  output logic                  err_ovf,
  output logic                  err_full
);

  typedef enum logic [2:0] {IDLE, CLEAR, SKIP, NUM, FIN} state_t;

  localparam int MW = DATA_WIDTH + 4;
  localparam logic [DATA_WIDTH-1:0] POS_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] NEG_MAX    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state, state_n;
  logic [ADDR_WIDTH:0]   clr_cnt, clr_cnt_n;
  logic [DATA_WIDTH-1:0] acc, acc_n, limit;
  logic                  neg, neg_n, has_digit, has_digit_n;
  logic                  commit, set_fmt, set_ovf;
  logic                  accept, is_digit, is_minus, is_sep;
  logic [MW-1:0]         prod;

  assign in_ready = (state == SKIP) || (state == NUM);
  assign accept   = in_valid && in_ready;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_minus = (in_data == 8'h2D);
  assign is_sep   = (in_data == 8'h20) || (in_data == 8'h2C) || (in_data == 8'h09) ||
                    (in_data == 8'h0A) || (in_data == 8'h0D);
  assign limit    = neg ? NEG_MAX : POS_MAX;
  assign prod     = ({4'b0, acc} * MW'(10)) + MW'(in_data[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Token values are taken from the *_n signals so a terminating digit on in_last is included.
  always_comb begin
    state_n     = state;
    clr_cnt_n   = clr_cnt;
    acc_n       = acc;
    neg_n       = neg;
    has_digit_n = has_digit;
    commit      = 1'b0;
    set_fmt     = 1'b0;
    set_ovf     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = CLEAR;
          clr_cnt_n = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt == FULL_COUNT) state_n = SKIP;
        else                       clr_cnt_n = clr_cnt + 1'b1;
      end
      SKIP: begin
        if (accept) begin
          if (is_digit) begin
            acc_n       = DATA_WIDTH'(in_data[3:0]);
            neg_n       = 1'b0;
            has_digit_n = 1'b1;
            state_n     = NUM;
          end else if (is_minus) begin
            acc_n       = '0;
            neg_n       = 1'b1;
            has_digit_n = 1'b0;
            state_n     = NUM;
          end else if (!is_sep) begin
            set_fmt = 1'b1;
          end
          if (in_last) begin
            commit  = (state_n == NUM);
            state_n = FIN;
          end
        end
      end
      NUM: begin
        if (accept) begin
          if (is_digit) begin
            if (prod > {4'b0, limit}) begin
              acc_n   = limit;
              set_ovf = 1'b1;
            end else begin
              acc_n = prod[DATA_WIDTH-1:0];
            end
            has_digit_n = 1'b1;
          end else begin
            commit  = 1'b1;
            state_n = SKIP;
            if (!is_sep) set_fmt = 1'b1;
          end
          if (in_last) begin
            commit  = 1'b1;
            state_n = FIN;
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt   <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      has_digit <= 1'b0;
      ram_clear <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      num_count <= '0;
      done      <= 1'b0;
      err_fmt   <= 1'b0;
      err_ovf   <= 1'b0;
      err_full  <= 1'b0;
    end else begin
      clr_cnt   <= clr_cnt_n;
      acc       <= acc_n;
      neg       <= neg_n;
      has_digit <= has_digit_n;
      ram_clear <= 1'b0;
      wr_en     <= 1'b0;
      done      <= (state == FIN);
      if (state == IDLE && start) begin
        ram_clear <= 1'b1;
        num_count <= '0;
        err_fmt   <= 1'b0;
        err_ovf   <= 1'b0;
        err_full  <= 1'b0;
      end
      if (set_fmt) err_fmt <= 1'b1;
      if (set_ovf) err_ovf <= 1'b1;
      // A lone '-' is a format error; a full RAM drops the value but keeps counting frozen.
      if (commit) begin
        if (!has_digit_n) begin
          err_fmt <= 1'b1;
        end else if (num_count == FULL_COUNT) begin
          err_full <= 1'b1;
        end else begin
          wr_en     <= 1'b1;
          wr_addr   <= num_count[ADDR_WIDTH-1:0];
          wr_data   <= neg_n ? -acc_n : acc_n;
          num_count <= num_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ascii_num_parser.sv
// Scoreboard bench for ascii_num_parser: a string-level reference model queues expected
// RAM writes and final flags; a monitor checks every write the DUT issues.
module tb_ascii_num_parser;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 2048;
  localparam int ADDR_WIDTH = 11;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  in_valid = 1'b0;
  logic [7:0]            in_data = 8'h00;
  logic                  in_last = 1'b0;
  logic                  in_ready, ram_clear, wr_en, done, err_fmt, err_ovf, err_full;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH:0]   num_count;

  int tests_run = 0;
  int tests_failed = 0;

  byte                   stim_q[$];
  logic [ADDR_WIDTH-1:0] exp_addr_q[$];
  logic [DATA_WIDTH-1:0] exp_data_q[$];
  int                    exp_count;
  bit                    exp_fmt, exp_ovf, exp_full;

  byte seps[5]    = '{8'h20, 8'h2C, 8'h09, 8'h0A, 8'h0D};
  byte illegal[4] = '{8'h61, 8'h2B, 8'h78, 8'h2E};

  ascii_num_parser #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .ram_clear(ram_clear), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .num_count(num_count), .done(done),
    .err_fmt(err_fmt), .err_ovf(err_ovf), .err_full(err_full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_addr_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
      end else begin
        checkOutput("wr_addr", 64'(wr_addr), 64'(exp_addr_q.pop_front()));
        checkOutput("wr_data", 64'(wr_data), 64'(exp_data_q.pop_front()));
      end
    end
  end

  function automatic bit isDigit(input byte c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit isSep(input byte c);
    foreach (seps[i]) if (c == seps[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic closeToken(input byte tok[$]);
    bit     neg;
    int     first;
    longint mag, limit;
    if (tok.size() == 0) return;
    neg   = (tok[0] == 8'h2D);
    first = neg ? 1 : 0;
    if (tok.size() == first) begin
      exp_fmt = 1'b1;
      return;
    end
    mag = 0;
    for (int i = first; i < tok.size(); i++) begin
      mag = mag * 10 + (longint'(tok[i]) - 48);
      if (mag > (64'sd1 << 40)) mag = 64'sd1 << 40;
    end
    limit = neg ? (64'sd1 << 31) : (64'sd1 << 31) - 1;
    if (mag > limit) begin
      exp_ovf = 1'b1;
      mag     = limit;
    end
    if (exp_count == DEPTH) begin
      exp_full = 1'b1;
    end else begin
      exp_addr_q.push_back(ADDR_WIDTH'(exp_count));
      exp_data_q.push_back(DATA_WIDTH'(neg ? -mag : mag));
      exp_count++;
    end
  endtask

  // Splits the stream into tokens at separators/illegal chars and evaluates each one.
  task automatic modelParse();
    byte tok[$];
    exp_count = 0;
    exp_fmt   = 1'b0;
    exp_ovf   = 1'b0;
    exp_full  = 1'b0;
    tok = {};
    foreach (stim_q[i]) begin
      if (isDigit(stim_q[i])) begin
        tok.push_back(stim_q[i]);
      end else if (stim_q[i] == 8'h2D && tok.size() == 0) begin
        tok.push_back(stim_q[i]);
      end else begin
        if (!isSep(stim_q[i])) exp_fmt = 1'b1;
        closeToken(tok);
        tok = {};
      end
    end
    closeToken(tok);
  endtask

  task automatic addString(input string s);
    for (int i = 0; i < s.len(); i++) stim_q.push_back(byte'(s[i]));
  endtask

  task automatic buildRandom();
    int ntok, kind, len;
    stim_q = {};
    ntok = $urandom_range(1, 12);
    for (int t = 0; t < ntok; t++) begin
      kind = $urandom_range(0, 9);
      if (kind < 3) stim_q.push_back(8'h2D);
      len = (kind == 9) ? $urandom_range(10, 13) : (kind == 8) ? 0 : $urandom_range(1, 5);
      for (int d = 0; d < len; d++) stim_q.push_back(8'(8'h30 + $urandom_range(0, 9)));
      if ($urandom_range(0, 7) == 0) stim_q.push_back(illegal[$urandom_range(0, 3)]);
      for (int s = 0; s < $urandom_range(1, 3); s++) stim_q.push_back(seps[$urandom_range(0, 4)]);
    end
    if ($urandom_range(0, 1) == 1)
      while (stim_q.size() > 1 && !isDigit(stim_q[stim_q.size()-1])) void'(stim_q.pop_back());
  endtask

  task automatic startParse();
    int cycles, clears;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checkOutput("count_cleared", 64'(num_count), 64'd0);
    checkOutput("errs_cleared", 64'({err_fmt, err_ovf, err_full}), 64'd0);
    cycles = 0;
    clears = 0;
    while (!in_ready && cycles < DEPTH + 20) begin
      cycles++;
      if (ram_clear) clears++;
      @(posedge clk); #1;
    end
    checkOutput("clear_cycles", 64'(cycles), 64'(DEPTH + 1));
    checkOutput("ram_clear_cycles", 64'(clears), 64'd1);
  endtask

  task automatic sendByte(input byte b, input bit last, output bit ok);
    int waits;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    waits    = 0;
    while (!in_ready && waits < 20) begin
      waits++;
      @(posedge clk); #1;
    end
    ok = in_ready;
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL in_ready_timeout: got in_ready 0, expected 1");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic applyStimulus(input int gap_pct);
    bit ok;
    int cycles;
    modelParse();
    startParse();
    foreach (stim_q[i]) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(posedge clk); #1;
      end
      sendByte(stim_q[i], i == stim_q.size() - 1, ok);
      if (!ok) return;
    end
    cycles = 0;
    while (!done && cycles < 10) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("done_latency", 64'(cycles), 64'd1);
    checkOutput("num_count", 64'(num_count), 64'(exp_count));
    checkOutput("err_fmt", 64'(err_fmt), 64'(exp_fmt));
    checkOutput("err_ovf", 64'(err_ovf), 64'(exp_ovf));
    checkOutput("err_full", 64'(err_full), 64'(exp_full));
    checkOutput("writes_outstanding", 64'(exp_addr_q.size()), 64'd0);
    exp_addr_q = {};
    exp_data_q = {};
    @(posedge clk); #1;
    checkOutput("done_pulse_width", 64'(done), 64'd0);
    checkOutput("count_holds", 64'(num_count), 64'(exp_count));
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1 checkOutput("reset_outputs", 64'({in_ready, ram_clear, wr_en, wr_addr, wr_data, num_count,
                                         done, err_fmt, err_ovf, err_full}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    stim_q = {}; addString("12, -7  0\n");               applyStimulus(0);
    stim_q = {}; addString("2147483648 -2147483648");    applyStimulus(30);
    stim_q = {}; addString("5a-3 - 4");                  applyStimulus(20);
    stim_q = {};
    for (int i = 0; i < DEPTH + 1; i++) addString("1 ");
    applyStimulus(0);

    // Abort mid-token, then confirm the next parse starts clean with no stray write.
    startParse();
    sendByte(8'h39, 1'b0, ok);
    sendByte(8'h38, 1'b0, ok);
    #2 rst_n = 1'b0;
    #1 checkOutput("abort_outputs", 64'({in_ready, ram_clear, wr_en, wr_addr, wr_data, num_count,
                                         done, err_fmt, err_ovf, err_full}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    stim_q = {}; addString("7\n"); applyStimulus(0);

    for (int r = 0; r < 8; r++) begin
      buildRandom();
      applyStimulus(25);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
